axi_rd_arbiter: RTL and testbench

// Shares the single read channel of axi_shim (rd_req/rd_gnt, rd_valid/rd_rdy) between NumReq refill requesters (e.g. L1I$ AXI wrapper, L1D$ refill).

---
 rtl/axi_rd_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// Purpose: round-robin share of the axi_shim read channel between NumReq refill requesters; returning beats routed by ID prefix.
// Latency: zero-cycle grant when the shim accepts in the arbitration cycle; beats pass through combinationally.
// Backpressure: an unaccepted request is held (no re-arbitration) until rd_gnt_i; beat ready follows the owning requester's rdy_i.
//
// Ports: clk_i/rst_i (sync active-high); per-requester req_i/gnt_o/addr_i/blen_i/size_i/id_i/lock_i;
//        per-requester rdy_i/valid_o plus broadcast data_o/last_o/id_o/exokay_o; idle_o/err_o status;
//        shim side rd_req_o/rd_gnt_i/rd_addr_o/rd_blen_o/rd_size_o/rd_lock_o/rd_id_o and
//        rd_valid_i/rd_last_i/rd_data_i/rd_id_i/rd_exokay_i/rd_rdy_o.
module axi_rd_arbiter #(
    parameter  int NumReq         = 2,
    parameter  int AxiAddrWidth   = 64,
    parameter  int AxiDataWidth   = 64,
    parameter  int ReqIdWidth     = 4,
    parameter  int BlenWidth      = 2,
    parameter  int MaxOutstanding = 4,
    localparam int IdxW           = $clog2(NumReq),
    localparam int AxiIdWidth     = ReqIdWidth + IdxW,
    localparam int CntW           = $clog2(MaxOutstanding + 1)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NumReq-1:0]              req_i,
    output logic [NumReq-1:0]              gnt_o,
    input  logic [NumReq*AxiAddrWidth-1:0] addr_i,
    input  logic [NumReq*BlenWidth-1:0]    blen_i,
    input  logic [NumReq*3-1:0]            size_i,
    input  logic [NumReq*ReqIdWidth-1:0]   id_i,
    input  logic [NumReq-1:0]              lock_i,
    input  logic [NumReq-1:0]              rdy_i,
    output logic [NumReq-1:0]              valid_o,
    output logic [AxiDataWidth-1:0]        data_o,
    output logic                           last_o,
    output logic [ReqIdWidth-1:0]          id_o,
    output logic                           exokay_o,
    output logic                           idle_o,
    output logic                           err_o,
    output logic                           rd_req_o,
    input  logic                           rd_gnt_i,
    output logic [AxiAddrWidth-1:0]        rd_addr_o,
    output logic [BlenWidth-1:0]           rd_blen_o,
    output logic [2:0]                     rd_size_o,
    output logic                           rd_lock_o,
    output logic [AxiIdWidth-1:0]          rd_id_o,
    input  logic                           rd_valid_i,
    input  logic                           rd_last_i,
    input  logic [AxiDataWidth-1:0]        rd_data_i,
    input  logic [AxiIdWidth-1:0]          rd_id_i,
    input  logic                           rd_exokay_i,
    output logic                           rd_rdy_o
);

    typedef enum logic {IDLE, HOLD} state_e;

    state_e          state_q;
    logic [IdxW-1:0] sel_q;
    logic [IdxW-1:0] ptr_q;
    logic [CntW-1:0] cnt_q [NumReq];
    logic            err_q;

    logic [NumReq-1:0] elig;
    logic [NumReq-1:0] cnt_nz;
    logic [NumReq-1:0] hit;
    logic [NumReq-1:0] dec;
    logic [IdxW-1:0]   arb_sel;
    logic              arb_vld;
    logic [IdxW-1:0]   cur_sel;
    logic [IdxW-1:0]   ptr_d;
    logic              grant;
    logic [IdxW-1:0]   owner;
    logic              owner_ok;
    logic              owner_rdy;
    logic              underflow;

    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            elig[i]   = req_i[i] & (cnt_q[i] < CntW'(MaxOutstanding));
            cnt_nz[i] = (cnt_q[i] != '0);
        end
    end

    // Rotate eligibility so bit 0 is the pointer position; scanning downward
    // lets the lowest rotated offset (closest to ptr) win.
    always_comb begin
        logic [2*NumReq-1:0] rot;
        logic [IdxW:0]       idx;
        rot     = {elig, elig} >> ptr_q;
        idx     = '0;
        arb_sel = '0;
        arb_vld = 1'b0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            if (rot[k]) begin
                idx = {1'b0, ptr_q} + (IdxW+1)'(k);
                if (idx >= (IdxW+1)'(NumReq)) begin
                    idx = idx - (IdxW+1)'(NumReq);
                end
                arb_sel = idx[IdxW-1:0];
                arb_vld = 1'b1;
            end
        end
    end

    assign cur_sel  = (state_q == HOLD) ? sel_q : arb_sel;
    assign rd_req_o = (state_q == HOLD) | arb_vld;
    assign grant    = rd_req_o & rd_gnt_i;
    assign ptr_d    = (cur_sel == IdxW'(NumReq - 1)) ? '0 : cur_sel + IdxW'(1);

    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            gnt_o[i] = grant & (cur_sel == IdxW'(i));
        end
    end

    assign rd_addr_o = addr_i[cur_sel*AxiAddrWidth +: AxiAddrWidth];
    assign rd_blen_o = blen_i[cur_sel*BlenWidth +: BlenWidth];
    assign rd_size_o = size_i[cur_sel*3 +: 3];
    assign rd_lock_o = lock_i[cur_sel];
    assign rd_id_o   = {cur_sel, id_i[cur_sel*ReqIdWidth +: ReqIdWidth]};

    // Response routing: the ID prefix names the owner. Prefixes beyond NumReq
    // (non power-of-two NumReq) are accepted and dropped so the shim never stalls.
    assign owner    = rd_id_i[AxiIdWidth-1:ReqIdWidth];
    assign owner_ok = ({1'b0, owner} < (IdxW+1)'(NumReq));

    always_comb begin
        owner_rdy = 1'b0;
        underflow = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            hit[i]     = owner_ok & (owner == IdxW'(i));
            valid_o[i] = rd_valid_i & hit[i];
            owner_rdy  = owner_rdy | (rdy_i[i] & hit[i]);
        end
        rd_rdy_o = owner_ok ? owner_rdy : 1'b1;
        for (int i = 0; i < NumReq; i++) begin
            dec[i]    = rd_valid_i & rd_rdy_o & rd_last_i & hit[i];
            underflow = underflow | (dec[i] & ~gnt_o[i] & ~cnt_nz[i]);
        end
    end

    assign data_o   = rd_data_i;
    assign last_o   = rd_last_i;
    assign id_o     = rd_id_i[ReqIdWidth-1:0];
    assign exokay_o = rd_exokay_i;
    assign err_o    = err_q;
    assign idle_o   = (state_q == IDLE) & ~|cnt_nz;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < NumReq; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (arb_vld) begin
                        if (rd_gnt_i) begin
                            ptr_q <= ptr_d;
                        end else begin
                            sel_q   <= arb_sel;
                            state_q <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (rd_gnt_i) begin
                        ptr_q   <= ptr_d;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Grant and final beat in the same cycle cancel out.
            for (int i = 0; i < NumReq; i++) begin
                case ({gnt_o[i], dec[i]})
                    2'b10:   cnt_q[i] <= cnt_q[i] + CntW'(1);
                    2'b01:   if (cnt_nz[i]) cnt_q[i] <= cnt_q[i] - CntW'(1);
                    default: cnt_q[i] <= cnt_q[i];
                endcase
            end

            if ((rd_valid_i & ~owner_ok) | underflow) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Purpose: directed self-checking bench for axi_rd_arbiter (2-requester instance plus a 3-requester instance for bad prefixes).
// Latency: inputs change 1 time unit after the rising edge; outputs are checked 2 units later.
// Backpressure: exercised directly through rd_gnt_i and rdy_i vectors.
module tb_axi_rd_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   tests = 0;
    int   fails = 0;

    // Two-requester instance, MaxOutstanding = 2
    logic [1:0]  req, gnt, lock, rdy, valid;
    logic [63:0] addr0, addr1, data;
    logic [1:0]  blen0, blen1, rd_blen;
    logic [2:0]  size0, size1, rd_size;
    logic [3:0]  id0, id1, id_out;
    logic        last, exokay, idle, err;
    logic        rd_req, rd_gnt, rd_lock, rd_valid, rd_last, rd_exokay, rd_rdy;
    logic [63:0] rd_addr, rd_data;
    logic [4:0]  rd_id, rd_id_in;

    axi_rd_arbiter #(.NumReq(2), .MaxOutstanding(2)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .req_i(req), .gnt_o(gnt),
        .addr_i({addr1, addr0}), .blen_i({blen1, blen0}), .size_i({size1, size0}),
        .id_i({id1, id0}), .lock_i(lock), .rdy_i(rdy),
        .valid_o(valid), .data_o(data), .last_o(last), .id_o(id_out),
        .exokay_o(exokay), .idle_o(idle), .err_o(err),
        .rd_req_o(rd_req), .rd_gnt_i(rd_gnt), .rd_addr_o(rd_addr), .rd_blen_o(rd_blen),
        .rd_size_o(rd_size), .rd_lock_o(rd_lock), .rd_id_o(rd_id),
        .rd_valid_i(rd_valid), .rd_last_i(rd_last), .rd_data_i(rd_data),
        .rd_id_i(rd_id_in), .rd_exokay_i(rd_exokay), .rd_rdy_o(rd_rdy)
    );

    // Three-requester instance: prefix 3 is out of range
    logic [2:0]   req3, gnt3, lock3, rdy3, valid3;
    logic [191:0] addr3;
    logic [5:0]   blen3;
    logic [8:0]   size3;
    logic [11:0]  idv3;
    logic [63:0]  data3, rd_addr3;
    logic [3:0]   id_out3;
    logic         last3, exokay3, idle3, err3;
    logic         rd_req3, rd_lock3, rd_valid3, rd_last3, rd_rdy3;
    logic [1:0]   rd_blen3;
    logic [2:0]   rd_size3;
    logic [5:0]   rd_id3, rd_id_in3;

    axi_rd_arbiter #(.NumReq(3), .MaxOutstanding(2)) u_dut3 (
        .clk_i(clk), .rst_i(rst),
        .req_i(req3), .gnt_o(gnt3),
        .addr_i(addr3), .blen_i(blen3), .size_i(size3),
        .id_i(idv3), .lock_i(lock3), .rdy_i(rdy3),
        .valid_o(valid3), .data_o(data3), .last_o(last3), .id_o(id_out3),
        .exokay_o(exokay3), .idle_o(idle3), .err_o(err3),
        .rd_req_o(rd_req3), .rd_gnt_i(1'b0), .rd_addr_o(rd_addr3), .rd_blen_o(rd_blen3),
        .rd_size_o(rd_size3), .rd_lock_o(rd_lock3), .rd_id_o(rd_id3),
        .rd_valid_i(rd_valid3), .rd_last_i(rd_last3), .rd_data_i(64'h0),
        .rd_id_i(rd_id_in3), .rd_exokay_i(1'b0), .rd_rdy_o(rd_rdy3)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [1:0] exp_g  [4];
    logic [4:0] exp_id [4];

    initial begin
        rst = 1'b1; req = '0; rd_gnt = 1'b0; rdy = '0; lock = '0;
        addr0 = '0; addr1 = '0; blen0 = '0; blen1 = '0; size0 = '0; size1 = '0;
        id0 = '0; id1 = '0;
        rd_valid = 1'b0; rd_last = 1'b0; rd_data = '0; rd_id_in = '0; rd_exokay = 1'b0;
        req3 = '0; lock3 = '0; rdy3 = '0; addr3 = '0; blen3 = '0; size3 = '0; idv3 = '0;
        rd_valid3 = 1'b0; rd_last3 = 1'b0; rd_id_in3 = '0;
        tick; tick; settle;
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_rd_req", rd_req, 1'b0);
        chk("rst_valid", valid, 2'b00);
        chk("rst_idle", idle, 1'b1);
        chk("rst_err", err, 1'b0);
        rst = 1'b0;

        // Single zero-latency grant and a two-beat burst
        tick;
        req = 2'b01; addr0 = 64'h8000_0040; blen0 = 2'd1; size0 = 3'd3; id0 = 4'h3; rd_gnt = 1'b1;
        settle;
        chk("t1_rd_req", rd_req, 1'b1);
        chk("t1_rd_id", rd_id, 5'h03);
        chk("t1_gnt", gnt, 2'b01);
        chk("t1_addr", rd_addr, 64'h8000_0040);
        chk("t1_blen", rd_blen, 2'd1);
        chk("t1_size", rd_size, 3'd3);
        tick;
        req = 2'b00; rd_gnt = 1'b0; rdy = 2'b11;
        rd_valid = 1'b1; rd_id_in = 5'h03; rd_data = 64'hDEAD_0001; rd_last = 1'b0;
        settle;
        chk("t1_idle_busy", idle, 1'b0);
        chk("t1_b1_valid", valid, 2'b01);
        chk("t1_b1_rdy", rd_rdy, 1'b1);
        chk("t1_b1_data", data, 64'hDEAD_0001);
        chk("t1_b1_last", last, 1'b0);
        chk("t1_b1_id", id_out, 4'h3);
        tick;
        rd_data = 64'hDEAD_0002; rd_last = 1'b1; rd_exokay = 1'b1;
        settle;
        chk("t1_b2_valid", valid, 2'b01);
        chk("t1_b2_last", last, 1'b1);
        chk("t1_b2_exokay", exokay, 1'b1);
        tick;
        rd_valid = 1'b0; rd_last = 1'b0; rd_exokay = 1'b0;
        settle;
        chk("t1_idle_after", idle, 1'b1);
        chk("t1_err", err, 1'b0);
        chk("t1_valid_off", valid, 2'b00);

        // Held request: ptr is 1, only req0 asks, shim stalls 3 cycles
        req = 2'b01; addr0 = 64'h1000; id0 = 4'h9; addr1 = 64'h2000; id1 = 4'hA;
        settle;
        chk("h0_rd_req", rd_req, 1'b1);
        chk("h0_gnt", gnt, 2'b00);
        chk("h0_addr", rd_addr, 64'h1000);
        tick;
        req = 2'b11;
        settle;
        chk("h1_addr", rd_addr, 64'h1000);
        chk("h1_rd_id", rd_id, 5'h09);
        chk("h1_gnt", gnt, 2'b00);
        chk("h1_idle", idle, 1'b0);
        tick; settle;
        chk("h2_addr", rd_addr, 64'h1000);
        tick;
        rd_gnt = 1'b1;
        settle;
        chk("h3_gnt", gnt, 2'b01);
        tick;
        req = 2'b10;
        settle;
        chk("h4_gnt", gnt, 2'b10);
        chk("h4_rd_id", rd_id, 5'h1A);
        chk("h4_addr", rd_addr, 64'h2000);
        tick;
        req = 2'b00; rd_gnt = 1'b0;
        rd_valid = 1'b1; rd_last = 1'b1; rd_id_in = 5'h00;
        tick;
        rd_id_in = 5'h10;
        tick;
        rd_valid = 1'b0; rd_last = 1'b0;
        settle;
        chk("h_drain_idle", idle, 1'b1);

        // Round robin with both requesting; ptr is 0, limit 2 per requester
        exp_g  = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_id = '{5'h02, 5'h17, 5'h02, 5'h17};
        req = 2'b11; rd_gnt = 1'b1; id0 = 4'h2; id1 = 4'h7;
        for (int k = 0; k < 4; k++) begin
            settle;
            chk($sformatf("rr%0d_gnt", k), gnt, exp_g[k]);
            chk($sformatf("rr%0d_id", k), rd_id, exp_id[k]);
            tick;
        end
        rd_valid = 1'b1; rd_last = 1'b1; rd_id_in = 5'h10;
        settle;
        chk("sat_rd_req", rd_req, 1'b0);
        chk("sat_gnt", gnt, 2'b00);
        tick;
        rd_valid = 1'b0;
        settle;
        chk("sat_req1_only", gnt, 2'b10);
        tick;
        rd_valid = 1'b1; rd_id_in = 5'h00;
        settle;
        chk("sat_req0_blocked", rd_req, 1'b0);
        tick;
        rd_valid = 1'b0;
        settle;
        chk("sat_req0_regrant", gnt, 2'b01);
        tick;
        req = 2'b00; rd_gnt = 1'b0;

        // Owner backpressure: cnt1 = 2, so req1 stays ineligible until its last beat completes
        rd_valid = 1'b1; rd_last = 1'b1; rd_id_in = 5'h12; rdy = 2'b01; req = 2'b10;
        settle;
        chk("bp0_rdy", rd_rdy, 1'b0);
        chk("bp0_valid", valid, 2'b10);
        chk("bp0_rd_req", rd_req, 1'b0);
        chk("bp0_id", id_out, 4'h2);
        tick; settle;
        chk("bp1_rdy", rd_rdy, 1'b0);
        chk("bp1_valid", valid, 2'b10);
        chk("bp1_rd_req", rd_req, 1'b0);
        tick;
        rdy = 2'b11;
        settle;
        chk("bp2_rdy", rd_rdy, 1'b1);
        tick;
        rd_valid = 1'b0; rd_last = 1'b0;
        settle;
        chk("bp3_rd_req", rd_req, 1'b1);
        req = 2'b00;
        tick;
        rd_valid = 1'b1; rd_last = 1'b1; rd_id_in = 5'h00;
        tick; tick;
        rd_id_in = 5'h10;
        tick;
        rd_valid = 1'b0; rd_last = 1'b0;
        settle;
        chk("bp_drain_idle", idle, 1'b1);
        chk("bp_drain_err", err, 1'b0);

        // Same-cycle grant and last beat leave the counter unchanged
        req = 2'b01; rd_gnt = 1'b1;
        settle;
        chk("id_gnt_a", gnt, 2'b01);
        tick;
        rd_valid = 1'b1; rd_last = 1'b1; rd_id_in = 5'h00;
        settle;
        chk("id_gnt_b", gnt, 2'b01);
        chk("id_valid", valid, 2'b01);
        tick;
        req = 2'b00; rd_gnt = 1'b0; rd_valid = 1'b0;
        settle;
        chk("id_busy", idle, 1'b0);
        rd_valid = 1'b1;
        tick;
        rd_valid = 1'b0;
        settle;
        chk("id_idle", idle, 1'b1);
        chk("id_err", err, 1'b0);

        // Last beat with nothing outstanding
        rd_valid = 1'b1;
        tick;
        rd_valid = 1'b0; rd_last = 1'b0;
        settle;
        chk("uf_err", err, 1'b1);
        chk("uf_idle", idle, 1'b1);
        tick; tick; settle;
        chk("uf_sticky", err, 1'b1);

        rst = 1'b1;
        tick;
        rst = 1'b0;
        settle;
        chk("rst2_err", err, 1'b0);
        chk("rst2_idle", idle, 1'b1);

        // Three requesters: valid prefix 2 routes, prefix 3 is dropped with error
        rd_valid3 = 1'b1; rd_id_in3 = 6'b10_0101; rd_last3 = 1'b0; rdy3 = 3'b100;
        settle;
        chk("n3_valid_p2", valid3, 3'b100);
        chk("n3_rdy_p2", rd_rdy3, 1'b1);
        chk("n3_err0", err3, 1'b0);
        tick;
        rd_id_in3 = 6'b11_0101; rdy3 = 3'b000; rd_last3 = 1'b1;
        settle;
        chk("n3_rdy_bad", rd_rdy3, 1'b1);
        chk("n3_valid_bad", valid3, 3'b000);
        tick;
        rd_valid3 = 1'b0; rd_last3 = 1'b0;
        settle;
        chk("n3_err_bad", err3, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
